// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the level-reporting FIFO
package fifo_pkg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // Pointers and level carry one extra bit: level reaches D+1 and pointers wrap mod 2*D.
    function automatic int fifo_level_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port RAM with a registered, enable-gated read port
module fifo_ram #(
    parameter int P_ADDR_WIDTH = 4,
    parameter int P_DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [P_ADDR_WIDTH-1:0] waddr,
    input  logic [P_DATA_WIDTH-1:0] wdata,
    input  logic                    re,
    input  logic [P_ADDR_WIDTH-1:0] raddr,
    output logic [P_DATA_WIDTH-1:0] rdata
);

    localparam int D = 1 << P_ADDR_WIDTH;

    logic [P_DATA_WIDTH-1:0] mem [D];

    // Storage is deliberately left unreset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_level.sv
// rtl/fifo_level.sv - FWFT sync FIFO with occupancy level, thresholds, flush and sticky errors
module fifo_level
    import fifo_pkg::*;
#(
    parameter int P_ADDR_WIDTH = 4,
    parameter int P_DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [P_DATA_WIDTH-1:0] data_in,
    output logic                    full,
    input  logic                    rd_en,
    output logic [P_DATA_WIDTH-1:0] data_out,
    output logic                    empty,
    output logic [P_ADDR_WIDTH:0]   level,
    input  logic [P_ADDR_WIDTH:0]   afull_level,
    input  logic [P_ADDR_WIDTH:0]   aempty_level,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = P_ADDR_WIDTH;
    localparam int LW = fifo_level_width(P_ADDR_WIDTH);

    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          head_valid;
    fifo_err_t     err_q;

    logic ram_empty;
    logic wr_acc;
    logic rd_acc;
    logic ready;
    logic load;

    assign ram_empty = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty     = !head_valid;

    // Full blocks a write even when a read frees space in the same cycle.
    assign wr_acc = wr_en && !full && !clr;
    assign rd_acc = rd_en && head_valid && !clr;
    assign ready  = rd_en || !head_valid;
    assign load   = ready && !ram_empty && !clr;

    fifo_ram #(
        .P_ADDR_WIDTH(P_ADDR_WIDTH),
        .P_DATA_WIDTH(P_DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (data_in),
        .re    (load),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (data_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            head_valid <= 1'b0;
        end else if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            head_valid <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + LW'(1);
            end
            if (load) begin
                rd_ptr     <= rd_ptr + LW'(1);
                head_valid <= 1'b1;
            end else if (ready && ram_empty) begin
                head_valid <= 1'b0;
            end
            // A RAM-to-head load does not change occupancy; only accepted pushes and pops do.
            case ({wr_acc, rd_acc})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Error flags survive a flush and clear only on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            if (wr_en && full && !clr) begin
                err_q.overflow <= 1'b1;
            end
            if (rd_en && !head_valid && !clr) begin
                err_q.underflow <= 1'b1;
            end
        end
    end

    assign level        = level_q;
    assign almost_full  = (level_q >= afull_level);
    assign almost_empty = (level_q <= aempty_level);
    assign overflow     = err_q.overflow;
    assign underflow    = err_q.underflow;

endmodule

// File: tb/tb_fifo_level.sv
// tb/tb_fifo_level.sv - randomized and directed self-checking bench for fifo_level
module tb_fifo_level;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int D  = 16;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic [LW-1:0] afull_level = 5'd12;
    logic [LW-1:0] aempty_level = 5'd3;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    fifo_level #(
        .P_ADDR_WIDTH(AW),
        .P_DATA_WIDTH(DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .full         (full),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .empty        (empty),
        .level        (level),
        .afull_level  (afull_level),
        .aempty_level (aempty_level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: whole contents as a queue, plus whether the head word is already visible.
    logic [DW-1:0] q[$];
    bit            hv;
    bit            m_ovf;
    bit            m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        q.delete();
        hv    = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_edge();
        int  in_ram;
        bit  m_full;
        bit  rd_ok;
        bit  wr_ok;
        bit  hv_next;
        in_ram = q.size() - int'(hv);
        m_full = (in_ram == D);
        if (clr) begin
            q.delete();
            hv = 1'b0;
        end else begin
            if (wr_en && m_full) m_ovf = 1'b1;
            if (rd_en && !hv)    m_unf = 1'b1;
            rd_ok   = rd_en && hv;
            wr_ok   = wr_en && !m_full;
            // A word becomes visible one edge after it was stored.
            hv_next = (hv && !rd_ok) || (in_ram > 0);
            if (rd_ok) void'(q.pop_front());
            if (wr_ok) q.push_back(data_in);
            hv = hv_next;
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check("level", level, n);
        check("empty", empty, !hv);
        check("full", full, (n - int'(hv)) == D);
        check("almost_full", almost_full, n >= int'(afull_level));
        check("almost_empty", almost_empty, n <= int'(aempty_level));
        check("overflow", overflow, m_ovf);
        check("underflow", underflow, m_unf);
        if (hv) check("data_out", data_out, q[0]);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_level"}, level, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_data"}, data_out, 0);
        check({tag, "_flags"}, {overflow, underflow}, 0);
        check({tag, "_aempty"}, almost_empty, 1);
        check({tag, "_afull"}, almost_full, afull_level == 0);
    endtask

    task automatic step(input bit c, input bit w, input logic [31:0] d, input bit r);
        clr     = c;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // fill 17 words then drain in order
        for (int i = 0; i <= D; i++) step(0, 1, i, 0);
        check("fill_full", full, 1);
        check("fill_level", level, 17);
        for (int i = 0; i <= D; i++) step(0, 0, 0, 1);
        check("drain_empty", empty, 1);
        check("drain_flags", {overflow, underflow}, 0);

        // full plus simultaneous read: write dropped, read accepted
        for (int i = 0; i <= D; i++) step(0, 1, i, 0);
        step(0, 1, 32'hAA, 1);
        check("ovf_set", overflow, 1);
        check("ovf_level", level, 16);
        check("ovf_head", data_out, 32'h01);
        check("ovf_full", full, 0);

        // empty read, then single-write latency
        for (int i = 0; i < D; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("unf_set", underflow, 1);
        step(0, 1, 32'h55, 0);
        check("lat_edge_n", empty, 1);
        step(0, 0, 0, 0);
        check("lat_edge_n1", empty, 0);
        check("lat_data", data_out, 32'h55);

        // thresholds
        step(1, 0, 0, 0);
        afull_level  = 5'd12;
        aempty_level = 5'd3;
        for (int i = 0; i < 11; i++) step(0, 1, 32'h100 + i, 0);
        check("afull_at11", almost_full, 0);
        step(0, 1, 32'h10B, 0);
        check("afull_at12", almost_full, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
        check("aempty_at4", almost_empty, 0);
        step(0, 0, 0, 1);
        check("aempty_at3", almost_empty, 1);
        afull_level = 5'd0;
        #1;
        check("afull_zero", almost_full, 1);

        // flush with a concurrent write
        for (int i = 0; i < 6; i++) step(0, 1, 32'h200 + i, 0);
        check("pre_flush_level", level, 9);
        step(1, 1, 32'h99, 0);
        check("flush_level", level, 0);
        check("flush_ovf", overflow, 1);
        step(0, 1, 32'h77, 0);
        step(0, 0, 0, 0);
        check("flush_fresh", data_out, 32'h77);
        afull_level = 5'd12;

        // asynchronous reset during a continuous stream
        for (int i = 0; i < 8; i++) step(0, 1, 32'h300 + i, i > 2);
        clr   = 1'b0;
        wr_en = 1'b1;
        rd_en = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_values("arst");
        model_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 32'hA0, 0);
        step(0, 1, 32'hA1, 0);
        step(0, 1, 32'hA2, 0);
        check("arst_order0", data_out, 32'hA0);
        step(0, 0, 0, 1);
        check("arst_order1", data_out, 32'hA1);

        // randomized traffic in phases biased toward full, empty, balanced and saturated
        for (int i = 0; i < 4000; i++) begin
            int ph;
            int pw;
            int pr;
            ph = (i / 250) % 4;
            pw = (ph == 0) ? 80 : (ph == 1) ? 30 : (ph == 2) ? 50 : 95;
            pr = (ph == 0) ? 30 : (ph == 1) ? 80 : (ph == 2) ? 50 : 95;
            if (i % 250 == 0) begin
                afull_level  = LW'($urandom_range(0, 31));
                aempty_level = LW'($urandom_range(0, 31));
            end
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < pw,
                 $urandom,
                 $urandom_range(0, 99) < pr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
